// File: rtl/hamming_encoder_stream.sv
// Streaming SECDED encoder: 11-bit words -> 16-bit extended Hamming(15,11) codewords,
// buffered in a small output FIFO. Define HAMMING_ERR_INJECT_EN to add error injection.
module hamming_encoder_stream #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_codeword,
  output logic [CNT_W-1:0] words_encoded
`ifdef HAMMING_ERR_INJECT_EN
  ,
  input  logic             err_inj_en,
  input  logic [15:0]      err_inj_mask,
  output logic [CNT_W-1:0] err_inj_count
`endif
);

  localparam int DATA_W = 11;
  localparam int CW_W   = 16;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = PTR_W + 1;

  // Data bits occupy the non-power-of-two positions; each parity bit covers the
  // positions whose index has the matching bit set, pos 0 closes overall parity.
  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    cw    = {d[10:4], 1'b0, d[3:1], 1'b0, d[0], 3'b000};
    cw[1] = ^(cw & 16'hAAA8);
    cw[2] = ^(cw & 16'hCCC8);
    cw[4] = ^(cw & 16'hF0E0);
    cw[8] = ^(cw & 16'hFE00);
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  logic [CW_W-1:0]  cw_p0;
  logic [CW_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occupancy;
  logic [CW_W-1:0]  last_pop_q;
  logic [CNT_W-1:0] word_cnt;
  logic             accept;
  logic             pop;

  // Stage p0: combinational encode of the presented word
  always_comb begin
    cw_p0 = encode(data_in);
`ifdef HAMMING_ERR_INJECT_EN
    if (err_inj_en) begin
      cw_p0 = cw_p0 ^ err_inj_mask;
    end
`endif
  end

  assign in_ready  = (occupancy < OCC_W'(FIFO_DEPTH)) & ~rst;
  assign out_valid = (occupancy != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Stage p1: FIFO storage and control
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      word_cnt  <= '0;
    end else begin
      if (accept) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= cw_p0;
    end
  end

  // Keeps the output defined (zero after reset, last popped word otherwise) while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pop_q <= '0;
    end else if (pop) begin
      last_pop_q <= fifo_mem[rd_ptr];
    end
  end

  assign out_codeword  = out_valid ? fifo_mem[rd_ptr] : last_pop_q;
  assign words_encoded = word_cnt;

`ifdef HAMMING_ERR_INJECT_EN
  logic [CNT_W-1:0] inj_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_cnt <= '0;
    end else if (accept && err_inj_en) begin
      inj_cnt <= inj_cnt + CNT_W'(1);
    end
  end

  assign err_inj_count = inj_cnt;
`endif

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Bench for hamming_encoder_stream: directed steps plus random traffic against a
// queue-based reference model. Define HAMMING_ERR_INJECT_EN to cover the injection path.
module tb_hamming_encoder_stream;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [10:0]      data_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_codeword;
  logic [CNT_W-1:0] words_encoded;
`ifdef HAMMING_ERR_INJECT_EN
  logic             err_inj_en = 1'b0;
  logic [15:0]      err_inj_mask = '0;
  logic [CNT_W-1:0] err_inj_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] model_q[$];
  int          cnt_m  = 0;
  int          inj_m  = 0;
  logic [15:0] last_m = '0;

  hamming_encoder_stream #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_codeword(out_codeword),
    .words_encoded(words_encoded)
`ifdef HAMMING_ERR_INJECT_EN
    , .err_inj_en(err_inj_en), .err_inj_mask(err_inj_mask), .err_inj_count(err_inj_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: place data bits in ascending non-power-of-two positions, then
  // derive each parity from the position indices, then overall parity.
  function automatic logic [15:0] ref_encode(input logic [10:0] d);
    logic [15:0] c;
    int j;
    logic par;
    c = '0;
    j = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 3; p < 16; p++) begin
        if (((p & (p - 1)) != 0) && (((p >> k) & 1) == 1)) par = par ^ c[p];
      end
      c[1 << k] = par;
    end
    par = 1'b0;
    for (int p = 1; p < 16; p++) par = par ^ c[p];
    c[0] = par;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the model at the negedge, then advance the model.
  task automatic cycle(input logic iv, input logic [10:0] d, input logic ordy,
                       input logic inj, input logic [15:0] mask, output logic [15:0] obs_cw);
    logic acc;
    logic [15:0] cw;
    @(posedge clk);
    #1;
    in_valid  = iv;
    data_in   = d;
    out_ready = ordy;
`ifdef HAMMING_ERR_INJECT_EN
    err_inj_en   = inj;
    err_inj_mask = mask;
`endif
    @(negedge clk);
    obs_cw = out_codeword;
    check("in_ready", 32'(in_ready), 32'(model_q.size() < FIFO_DEPTH));
    check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) check("codeword", 32'(out_codeword), 32'(model_q[0]));
    else check("idle_codeword", 32'(out_codeword), 32'(last_m));
    check("words_encoded", 32'(words_encoded), 32'(cnt_m[CNT_W-1:0]));
`ifdef HAMMING_ERR_INJECT_EN
    check("err_inj_count", 32'(err_inj_count), 32'(inj_m[CNT_W-1:0]));
`endif
    acc = iv && (model_q.size() < FIFO_DEPTH);
    if (ordy && model_q.size() != 0) last_m = model_q.pop_front();
    if (acc) begin
      cw = ref_encode(d);
`ifdef HAMMING_ERR_INJECT_EN
      if (inj) begin
        cw = cw ^ mask;
        inj_m++;
      end
`endif
      model_q.push_back(cw);
      cnt_m++;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      if (i > 0) check("rst_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    cnt_m = 0; inj_m = 0; last_m = '0;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_codeword", 32'(out_codeword), 32'd0);
    check("rel_words", 32'(words_encoded), 32'd0);
  endtask

  task automatic single(input logic [10:0] d, input logic [15:0] exp);
    logic [15:0] o;
    cycle(1'b1, d, 1'b1, 1'b0, 16'h0, o);
    cycle(1'b0, 11'h0, 1'b1, 1'b0, 16'h0, o);
    check("single_const", 32'(o), 32'(exp));
  endtask

  initial begin
    logic [15:0] o;

    // Reset held three cycles
    do_reset(3);

    // Known single-word codewords, one cycle latency
    single(11'h000, 16'h0000);
    single(11'h001, 16'h000F);
    single(11'h400, 16'h8117);
    single(11'h7FF, 16'hFFFF);

    // Back-to-back stream at full rate
    do_reset(1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 11'(i), 1'b1, 1'b0, 16'h0, o);
    cycle(1'b0, 11'h0, 1'b1, 1'b0, 16'h0, o);
    check("stream_count", 32'(words_encoded), 32'd10);

    // Fill with downstream stalled, hold, then a pop while full must not admit a word
    for (int i = 0; i < FIFO_DEPTH + 2; i++) cycle(1'b1, 11'(12'h100 + i), 1'b0, 1'b0, 16'h0, o);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", 32'(out_codeword), 32'(ref_encode(11'h100)));
    cycle(1'b1, 11'h555, 1'b1, 1'b0, 16'h0, o);
    for (int i = 0; i < FIFO_DEPTH + 2; i++) cycle(1'b0, 11'h0, 1'b1, 1'b0, 16'h0, o);

    // Reset while full discards buffered words
    for (int i = 0; i < FIFO_DEPTH; i++) cycle(1'b1, 11'(12'h2A0 + i), 1'b0, 1'b0, 16'h0, o);
    do_reset(2);
    cycle(1'b0, 11'h0, 1'b1, 1'b0, 16'h0, o);
    check("post_rst_empty", 32'(out_valid), 32'd0);

`ifdef HAMMING_ERR_INJECT_EN
    cycle(1'b1, 11'h001, 1'b1, 1'b1, 16'h0008, o);
    cycle(1'b0, 11'h0, 1'b1, 1'b0, 16'h0, o);
    check("inj_codeword", 32'(o), 32'h0007);
    check("inj_count", 32'(err_inj_count), 32'd1);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] m;
      logic [3:0] syn;
      int sel;
      sel = i % 3;
      m = '0;
      if (sel >= 1) m[$urandom_range(15, 0)] = 1'b1;
      if (sel == 2) begin
        int a;
        a = $urandom_range(15, 0);
        while (m[a]) a = (a + 1) % 16;
        m[a] = 1'b1;
      end
      cycle(1'b1, 11'($urandom), 1'b1, (sel != 0), m, o);
      cycle(1'b0, 11'h0, 1'b1, 1'b0, 16'h0, o);
      syn = '0;
      for (int p = 1; p < 16; p++) if (o[p]) syn = syn ^ 4'(p);
      check("sed", 32'((^o) == 1'b1), 32'(sel == 1));
      check("ded", 32'((^o) == 1'b0 && syn != 0), 32'(sel == 2));
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 11'($urandom), 1'($urandom_range(3, 0) != 0), 1'b0, 16'h0, o);
    end
    for (int i = 0; i < FIFO_DEPTH + 1; i++) cycle(1'b0, 11'h0, 1'b1, 1'b0, 16'h0, o);
    check("final_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
